// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver: conditions the raw pad signals, deframes
// scancode bytes and keeps the Hack keyboard register (held key code, 0 if none).
module ps2_keyboard #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          flip;
    logic          fall;

    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          start_bad;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          stop_edge;
    logic          frame_ok;
    logic          byte_ok;
    logic          byte_bad;

    state_t        state;
    state_t        state_n;
    logic [7:0]    key_n;
    logic [7:0]    mapped;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Level flips on the FILTER_LEN-th consecutive sample that disagrees.
    assign flip = (clk_sync[1] != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall = flip && filt_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
        end else if (flip) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    assign timeout   = (to_cnt == TW'(TIMEOUT));
    assign stop_edge = fall && (bit_cnt == 4'd10);
    assign frame_ok  = !start_bad && (^{shreg, par_bit}) && data_sync[1];
    assign byte_ok   = stop_edge && frame_ok;
    assign byte_bad  = (stop_edge && !frame_ok) || (timeout && !fall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            start_bad <= 1'b0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
        end else if (fall) begin
            to_cnt <= '0;
            case (bit_cnt)
                4'd0:    start_bad <= data_sync[1];
                4'd9:    par_bit   <= data_sync[1];
                4'd10:   ;
                default: shreg     <= {data_sync[1], shreg[7:1]};
            endcase
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end else if (timeout) begin
            bit_cnt <= 4'd0;
            to_cnt  <= '0;
        end else if (bit_cnt != 4'd0 && to_cnt != TW'(TIMEOUT)) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scancode to Hack code map; 0 means unmapped
    // ------------------------------------------------------------------
    function automatic logic [7:0] map_code(input logic [7:0] sc, input logic ext);
        case ({ext, sc})
            9'h01C: map_code = 8'd65;   // A
            9'h032: map_code = 8'd66;
            9'h021: map_code = 8'd67;
            9'h023: map_code = 8'd68;
            9'h024: map_code = 8'd69;
            9'h02B: map_code = 8'd70;
            9'h034: map_code = 8'd71;
            9'h033: map_code = 8'd72;
            9'h043: map_code = 8'd73;
            9'h03B: map_code = 8'd74;
            9'h042: map_code = 8'd75;
            9'h04B: map_code = 8'd76;
            9'h03A: map_code = 8'd77;
            9'h031: map_code = 8'd78;
            9'h044: map_code = 8'd79;
            9'h04D: map_code = 8'd80;
            9'h015: map_code = 8'd81;
            9'h02D: map_code = 8'd82;
            9'h01B: map_code = 8'd83;
            9'h02C: map_code = 8'd84;
            9'h03C: map_code = 8'd85;
            9'h02A: map_code = 8'd86;
            9'h01D: map_code = 8'd87;
            9'h022: map_code = 8'd88;
            9'h035: map_code = 8'd89;
            9'h01A: map_code = 8'd90;   // Z
            9'h045: map_code = 8'd48;   // 0
            9'h016: map_code = 8'd49;
            9'h01E: map_code = 8'd50;
            9'h026: map_code = 8'd51;
            9'h025: map_code = 8'd52;
            9'h02E: map_code = 8'd53;
            9'h036: map_code = 8'd54;
            9'h03D: map_code = 8'd55;
            9'h03E: map_code = 8'd56;
            9'h046: map_code = 8'd57;   // 9
            9'h029: map_code = 8'd32;
            9'h05A: map_code = 8'd128;
            9'h066: map_code = 8'd129;
            9'h076: map_code = 8'd140;
            9'h16B: map_code = 8'd130;
            9'h175: map_code = 8'd131;
            9'h174: map_code = 8'd132;
            9'h172: map_code = 8'd133;
            default: map_code = 8'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Prefix decoder and key register
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state;
        key_n   = key;
        mapped  = 8'd0;
        if (byte_bad) begin
            state_n = IDLE;
        end else if (byte_ok) begin
            case (state)
                IDLE: begin
                    if (shreg == 8'hE0) begin
                        state_n = EXT;
                    end else if (shreg == 8'hF0) begin
                        state_n = BRK;
                    end else begin
                        mapped = map_code(shreg, 1'b0);
                        if (mapped != 8'd0) key_n = mapped;
                    end
                end
                EXT: begin
                    if (shreg == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else begin
                        mapped  = map_code(shreg, 1'b1);
                        if (mapped != 8'd0) key_n = mapped;
                        state_n = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    mapped  = map_code(shreg, state == EXT_BRK);
                    if (mapped != 8'd0 && key == mapped) key_n = 8'd0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            key        <= 8'd0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            key        <= key_n;
            code_valid <= byte_ok;
            frame_err  <= byte_bad;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized bench for ps2_keyboard against a scancode-level model of the
// Hack keyboard register.
module tb_ps2_keyboard;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       code_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_keyboard #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Letters A..Z then digits 0..9, in Hack-code order.
    logic [7:0] scan_tab [36] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    logic [7:0] extra_tab [8] = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h6B, 8'h75, 8'h74, 8'h72};

    function automatic logic [7:0] model_map(input logic [7:0] sc, input bit ext);
        if (ext) begin
            if (sc == 8'h6B) return 8'd130;
            if (sc == 8'h75) return 8'd131;
            if (sc == 8'h74) return 8'd132;
            if (sc == 8'h72) return 8'd133;
            return 8'd0;
        end
        for (int i = 0; i < 36; i++)
            if (scan_tab[i] == sc) return (i < 26) ? 8'(65 + i) : 8'(22 + i);
        if (sc == 8'h29) return 8'd32;
        if (sc == 8'h5A) return 8'd128;
        if (sc == 8'h66) return 8'd129;
        if (sc == 8'h76) return 8'd140;
        return 8'd0;
    endfunction

    logic [7:0] m_key = 8'd0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [7:0] code;
        if (!ok) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1'b1;
        end else begin
            code = model_map(b, m_ext);
            if (code != 8'd0) begin
                if (!m_brk) m_key = code;
                else if (m_key == code) m_key = 8'd0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Pulse counters and per-cycle protocol checks.
    int         cv_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] prev_key = 8'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_key <= key;
        end else begin
            if (code_valid) cv_cnt <= cv_cnt + 1;
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (code_valid || frame_err) check("pulse_excl", 32'(code_valid & frame_err), 0);
            if (key !== prev_key) check("key_chg_needs_cv", 32'(code_valid), 1);
            prev_key <= key;
        end
    end

    task automatic send_frame(input logic [7:0] b, input int nbits,
                              input bit bad_start, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_start, input bit bad_par, input bit bad_stop);
        int cv0;
        int fe0;
        bit ok;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        ok  = !(bad_start || bad_par || bad_stop);
        send_frame(b, 11, bad_start, bad_par, bad_stop);
        @(negedge clk);
        model_byte(b, ok);
        check("code_valid_pulses", 32'(cv_cnt - cv0), 32'(ok));
        check("frame_err_pulses", 32'(fe_cnt - fe0), 32'(!ok));
        check("key", 32'(key), 32'(m_key));
    endtask

    task automatic good(input logic [7:0] b);
        frame(b, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cv0;
        int fe0;
        int r;
        logic [7:0] b;

        repeat (5) @(negedge clk);
        check("rst_key", 32'(key), 0);
        check("rst_code_valid", 32'(code_valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Make then break of A.
        good(8'h1C);
        check("A_make", 32'(key), 65);
        cv0 = cv_cnt;
        good(8'hF0);
        good(8'h1C);
        check("A_break", 32'(key), 0);
        check("A_break_cv", 32'(cv_cnt - cv0), 2);

        // Extended keys, and a non-extended break that must not release them.
        good(8'hE0); good(8'h75);
        check("up_make", 32'(key), 131);
        good(8'hE0); good(8'hF0); good(8'h75);
        check("up_break", 32'(key), 0);
        good(8'hE0); good(8'h74);
        good(8'hF0); good(8'h74);
        check("right_kept", 32'(key), 132);

        // Last key pressed wins; stale break ignored.
        good(8'h1C); check("roll_A", 32'(key), 65);
        good(8'h32); check("roll_B", 32'(key), 66);
        good(8'hF0); good(8'h1C); check("stale_break", 32'(key), 66);
        good(8'hF0); good(8'h32); check("B_break", 32'(key), 0);

        // Bad parity, stop and start bits leave key alone.
        good(8'h1C);
        frame(8'h1C, 1'b0, 1'b1, 1'b0);
        frame(8'h1C, 1'b0, 1'b0, 1'b1);
        frame(8'h32, 1'b1, 1'b0, 1'b0);
        check("err_key_kept", 32'(key), 65);

        // Partial frame then idle beyond the timeout.
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1C, 5, 1'b0, 1'b0, 1'b0);
        repeat (TIMEOUT + 200) @(posedge clk);
        @(negedge clk);
        model_byte(8'h00, 1'b0);
        check("timeout_fe", 32'(fe_cnt - fe0), 1);
        check("timeout_cv", 32'(cv_cnt - cv0), 0);
        good(8'h29); check("space", 32'(key), 32);
        good(8'h05); check("unmapped_kept", 32'(key), 32);

        // Reset asserted mid-frame.
        send_frame(8'h1C, 7, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_key", 32'(key), 0);
        check("midrst_cv", 32'(code_valid), 0);
        reset = 1'b0;
        m_key = 8'd0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) @(negedge clk);
        good(8'h5A); check("enter", 32'(key), 128);

        // Random scancode stream.
        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      b = scan_tab[$urandom_range(0, 35)];
            else if (r < 50) b = extra_tab[$urandom_range(0, 7)];
            else if (r < 65) b = 8'hE0;
            else if (r < 80) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            if (r >= 92) begin
                r = $urandom_range(0, 2);
                frame(b, r == 0, r == 1, r == 2);
            end else begin
                good(b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
